// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler.
// Contents: FSM state encoding, the counter value type and the default
// requester count and counter width.
package counter_sched_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Round-robin arbiter used by counter_scheduler.
// Purely combinational. The search starts at last_winner_i + 1 (mod NUM_REQ)
// and moves upward. The caller owns the pointer register and decides when it
// advances.
// Ports:
//   req_i          request vector
//   last_winner_i  index of the previous winner (the pointer)
//   pick_o         one-hot winner (all zero if nothing is requested)
//   pick_idx_o     winner index
//   valid_o        high when at least one request is set
module rr_arbiter import counter_sched_pkg::*; #(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_winner_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   pick_idx_o,
  output logic               valid_o
);

  // cand_idx[k] is the requester at search distance k+1 from the pointer.
  logic [IDX_W-1:0] cand_idx [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = IDX_W'((int'(last_winner_i) + 1 + gi) % NUM_REQ);
  end

  // Scan from the farthest candidate toward the nearest. A later hit
  // overwrites an earlier one, so the nearest set request wins.
  always_comb begin
    pick_o     = '0;
    pick_idx_o = '0;
    valid_o    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[cand_idx[k]]) begin
        pick_idx_o = cand_idx[k];
        valid_o    = 1'b1;
      end
    end
    if (valid_o) begin
      pick_o[pick_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one up-counter among NUM_REQ requesters.
// An idle request is accepted through the round-robin arbiter. The counter
// then runs from 0 to len-1, and completion is signalled to the owner.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   req           per-requester request levels
//   req_len       packed lengths; slice i belongs to req[i]; 0 is run as 1
//   abort         cancels a run in progress (ignored while idle)
//   grant         one-hot acceptance pulse in the first RUN cycle
//   done          one-hot completion pulse in the DONE cycle
//   busy          high whenever the FSM is not idle
//   owner         index of the current or last winner
//   count         shared counter value
module counter_scheduler import counter_sched_pkg::*; #(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_len,
  input  logic                     abort,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [IDX_W-1:0]         owner,
  output logic [WIDTH-1:0]         count
);

  state_t             state_q;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   len_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] win_oh_q;
  logic               busy_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_q;

  logic [WIDTH-1:0]   len_arr [NUM_REQ];
  logic [WIDTH-1:0]   sel_len;
  logic [WIDTH-1:0]   len_d;
  logic [NUM_REQ-1:0] arb_pick;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_len
    assign len_arr[gi] = req_len[gi*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i         (req),
    .last_winner_i (last_q),
    .pick_o        (arb_pick),
    .pick_idx_o    (arb_idx),
    .valid_o       (arb_valid)
  );

  // A zero length is run as one cycle, so the compare against len-1 below
  // can never underflow.
  always_comb begin
    sel_len = len_arr[arb_idx];
    len_d   = (sel_len == '0) ? WIDTH'(1) : sel_len;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      len_q    <= WIDTH'(1);
      grant_q  <= '0;
      done_q   <= '0;
      win_oh_q <= '0;
      busy_q   <= 1'b0;
      owner_q  <= '0;
      // Pointer starts on the last index so req[0] has highest priority.
      last_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            state_q  <= RUN;
            count_q  <= '0;
            len_q    <= len_d;
            owner_q  <= arb_idx;
            win_oh_q <= arb_pick;
            grant_q  <= arb_pick;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            // Count stays frozen; the pointer still moves past the owner.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            last_q  <= owner_q;
          end else if (count_q == len_q - WIDTH'(1)) begin
            state_q <= DONE;
            done_q  <= win_oh_q;
          end else begin
            count_q <= count_q + WIDTH'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          last_q  <= owner_q;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign count = count_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler.
// Expected grant and done events are queued when stimulus is driven, and a
// monitor pops them as the DUT produces pulses.
module tb_counter_scheduler;

  localparam int NR = 4;
  localparam int W  = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR*W-1:0] req_len = '0;
  logic            abort = 1'b0;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   done;
  logic            busy;
  logic [1:0]      owner;
  logic [W-1:0]    count;

  counter_scheduler #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .req_len (req_len),
    .abort   (abort),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .owner   (owner),
    .count   (count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gcyc     = 0;

  typedef struct {
    bit is_done;
    int idx;
    int lat;
  } ev_t;

  ev_t exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_run(input int idx, input int lat, input bit completes);
    ev_t e;
    e.is_done = 1'b0; e.idx = idx; e.lat = 0;
    exp_q.push_back(e);
    if (completes) begin
      e.is_done = 1'b1; e.lat = lat;
      exp_q.push_back(e);
    end
  endtask

  task automatic set_len(input int idx, input logic [W-1:0] v);
    req_len[idx*W +: W] = v;
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      @(negedge clock);
      if (grant != '0) seen++;
      t++;
    end
    if (seen < n) check_eq("grant_timeout", 64'(seen), 64'(n));
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clock);
      t++;
    end
    check_eq("queue_drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_count(input string tag, input logic [W-1:0] v, input int budget);
    int t = 0;
    while (count != v && t < budget) begin
      @(negedge clock);
      t++;
    end
    check_eq(tag, 64'(count), 64'(v));
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard monitor: every grant/done pulse must match the queue head.
  always @(negedge clock) begin
    ev_t e;
    logic [NR-1:0] oh;
    if (grant != '0 && done != '0) check_eq("grant_done_overlap", {grant, done}, 64'd0);
    if (grant != '0 || done != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", {grant, done}, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        oh = NR'(1) << e.idx;
        if (e.is_done) begin
          $display("cycle %0d: done  idx %0d latency %0d count %0d", cyc, e.idx, cyc - gcyc, count);
          check_eq("done_vec", 64'(done), 64'(oh));
          check_eq("done_latency", 64'(cyc - gcyc), 64'(e.lat));
        end else begin
          $display("cycle %0d: grant idx %0d count %0d", cyc, e.idx, count);
          check_eq("grant_vec", 64'(grant), 64'(oh));
          check_eq("grant_count", 64'(count), 64'd0);
          check_eq("grant_owner", 64'(owner), 64'(e.idx));
          gcyc = cyc;
        end
      end
    end
  end

  initial begin
    int g;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_done",  64'(done),  64'd0);
    check_eq("rst_busy",  64'(busy),  64'd0);
    check_eq("rst_owner", 64'(owner), 64'd0);
    drive_edge();
    reset = 1'b0;

    // Single request, len 5 on req[2]
    set_len(2, 16'd5);
    expect_run(2, 5, 1'b1);
    req = 4'b0100;
    wait_grants(1, 10);
    drive_edge();
    req = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      check_eq("t1_count", 64'(count), 64'(i));
    end
    @(negedge clock);
    check_eq("t1_count_hold", 64'(count), 64'd4);
    check_eq("t1_busy_done",  64'(busy),  64'd1);
    @(negedge clock);
    check_eq("t1_busy_low",   64'(busy),  64'd0);
    drain(5);

    // All four requesting, len 1 each, after a fresh reset
    drive_edge();
    reset = 1'b1;
    drive_edge();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_len(i, 16'd1);
    expect_run(0, 1, 1'b1);
    expect_run(1, 1, 1'b1);
    expect_run(2, 1, 1'b1);
    expect_run(3, 1, 1'b1);
    expect_run(0, 1, 1'b1);
    req = 4'b1111;
    wait_grants(5, 40);
    drive_edge();
    req = '0;
    drain(10);
    check_eq("t2_owner", 64'(owner), 64'd0);

    // len 0 behaves as len 1
    set_len(1, 16'd0);
    expect_run(1, 1, 1'b1);
    drive_edge();
    req = 4'b0010;
    wait_grants(1, 10);
    drive_edge();
    req = '0;
    drain(5);

    // Abort at count 3 of len 10 on req[3]
    set_len(3, 16'd10);
    expect_run(3, 10, 1'b0);
    drive_edge();
    req = 4'b1000;
    wait_grants(1, 10);
    drive_edge();
    req = '0;
    wait_count("t4_reach3", 16'd3, 20);
    abort = 1'b1;
    drive_edge();
    abort = 1'b0;
    @(negedge clock);
    check_eq("t4_busy",  64'(busy),  64'd0);
    check_eq("t4_count", 64'(count), 64'd3);
    check_eq("t4_owner", 64'(owner), 64'd3);
    repeat (3) @(negedge clock);
    check_eq("t4_count_idle", 64'(count), 64'd3);
    set_len(0, 16'd1);
    set_len(3, 16'd1);
    expect_run(0, 1, 1'b1);
    drive_edge();
    req = 4'b1001;
    wait_grants(1, 10);
    drive_edge();
    req = '0;
    drain(5);

    // Reset pulsed mid-run at count 7
    set_len(2, 16'd20);
    expect_run(2, 20, 1'b0);
    drive_edge();
    req = 4'b0100;
    wait_grants(1, 10);
    drive_edge();
    req = '0;
    wait_count("t5_reach7", 16'd7, 20);
    reset = 1'b1;
    drive_edge();
    reset = 1'b0;
    @(negedge clock);
    check_eq("t5_count", 64'(count), 64'd0);
    check_eq("t5_busy",  64'(busy),  64'd0);
    check_eq("t5_done",  64'(done),  64'd0);
    check_eq("t5_owner", 64'(owner), 64'd0);
    expect_run(0, 1, 1'b1);
    expect_run(3, 1, 1'b1);
    drive_edge();
    req = 4'b1001;
    wait_grants(2, 20);
    drive_edge();
    req = '0;
    drain(5);

    // Maximum length: counter reaches 0xFFFE and never wraps
    set_len(1, 16'hFFFF);
    expect_run(1, 65535, 1'b1);
    drive_edge();
    req = 4'b0010;
    wait_grants(1, 10);
    g = cyc;
    drive_edge();
    req = '0;
    wait_count("t6_reach_max", 16'hFFFE, 70000);
    check_eq("t6_last_run_cycle", 64'(cyc - g), 64'd65534);
    @(negedge clock);
    check_eq("t6_no_wrap", 64'(count), 64'hFFFE);
    check_eq("t6_done",    64'(done),  64'b0010);
    drain(5);

    repeat (4) @(negedge clock);
    check_eq("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check_eq("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
